// File: rtl/reaction_stimulus_ctrl_pkg.sv
// Shared types and constants for the reaction-timer stimulus block.
package reaction_stimulus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LIT  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Galois mask for x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned MS_W = 14;

endpackage

// File: rtl/reaction_lfsr16.sv
// 16-bit Galois LFSR stepping every clock; a zero seed is replaced by 1 so it never locks up.
module reaction_lfsr16
  import reaction_stimulus_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [15:0] seed_safe;

  always_comb begin
    seed_safe = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) lfsr_q <= seed_safe;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/reaction_stimulus_ctrl.sv
// Reaction-timer stimulus: random pre-delay, LED on, then end on reaction, false start or timeout.
module reaction_stimulus_ctrl
  import reaction_stimulus_ctrl_pkg::*;
#(
  parameter int unsigned CLK_PER_MS   = 100000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RANGE_BITS   = 12,
  parameter int unsigned TIMEOUT_MS   = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk_100MHz,
  input  logic clear,
  input  logic start,
  input  logic reaction_switch,
  output logic led_on,
  output logic clear_display,
  output logic busy,
  output logic false_start,
  output logic timeout
);

  localparam int unsigned PRESC_W = $clog2(CLK_PER_MS);
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0]    MIN_DELAY   = MS_W'(MIN_DELAY_MS);
  localparam logic [MS_W-1:0]    TIMEOUT_PRE = MS_W'(TIMEOUT_MS - 1);
  localparam logic [15:0]        RANGE_MASK  = 16'((32'd1 << RANGE_BITS) - 32'd1);

  logic start_s1_q, start_s_q, start_dly_q;
  logic sw_s1_q, sw_s_q;
  logic start_edge, ms_tick;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic                led_q, led_d;
  logic                clrd_q, clrd_d;
  logic                busy_q, busy_d;
  logic                fs_q, fs_d;
  logic                to_q, to_d;
  logic [15:0]         lfsr;
  logic [15:0]         extra;

  reaction_lfsr16 u_lfsr (
    .clk_i   (clk_100MHz),
    .clear_i (clear),
    .seed_i  (LFSR_SEED),
    .state_o (lfsr)
  );

  assign start_edge = start_s_q & ~start_dly_q;
  assign ms_tick    = (presc_q == PRESC_LAST);
  assign extra      = lfsr & RANGE_MASK;

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    state_d = state_q;
    presc_d = ms_tick ? '0 : presc_q + PRESC_W'(1);
    ms_d    = ms_q;
    led_d   = led_q;
    clrd_d  = clrd_q;
    busy_d  = busy_q;
    fs_d    = fs_q;
    to_d    = to_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == IDLE) begin
          led_d  = 1'b0;
          clrd_d = 1'b0;
          busy_d = 1'b0;
        end
        if (start_edge && !sw_s_q) begin
          state_d = WAIT;
          presc_d = '0;
          ms_d    = MIN_DELAY + MS_W'(extra);
          led_d   = 1'b0;
          clrd_d  = 1'b1;
          busy_d  = 1'b1;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end
      end
      WAIT: begin
        if (sw_s_q) begin
          state_d = DONE;
          fs_d    = 1'b1;
          led_d   = 1'b0;
          clrd_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (ms_tick) begin
          if (ms_q <= MS_W'(1)) begin
            state_d = LIT;
            presc_d = '0;
            ms_d    = '0;
            led_d   = 1'b1;
            clrd_d  = 1'b0;
          end else begin
            ms_d = ms_q - MS_W'(1);
          end
        end
      end
      LIT: begin
        if (sw_s_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end else if (ms_tick) begin
          ms_d = ms_q + MS_W'(1);
          if (ms_q == TIMEOUT_PRE) begin
            state_d = DONE;
            to_d    = 1'b1;
            led_d   = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (clear) begin
      start_s1_q  <= 1'b0;
      start_s_q   <= 1'b0;
      start_dly_q <= 1'b0;
      sw_s1_q     <= 1'b0;
      sw_s_q      <= 1'b0;
      state_q     <= IDLE;
      presc_q     <= '0;
      ms_q        <= '0;
      led_q       <= 1'b0;
      clrd_q      <= 1'b0;
      busy_q      <= 1'b0;
      fs_q        <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      start_s1_q  <= start;
      start_s_q   <= start_s1_q;
      start_dly_q <= start_s_q;
      sw_s1_q     <= reaction_switch;
      sw_s_q      <= sw_s1_q;
      state_q     <= state_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      led_q       <= led_d;
      clrd_q      <= clrd_d;
      busy_q      <= busy_d;
      fs_q        <= fs_d;
      to_q        <= to_d;
    end
  end

  assign led_on        = led_q;
  assign clear_display = clrd_q;
  assign busy          = busy_q;
  assign false_start   = fs_q;
  assign timeout       = to_q;

endmodule
